i2s_clock_gen: RTL and testbench
================================

# i2s_clock_gen

Parametrised I2S/TDM bit-clock and frame-clock generator for the microphone capture path. It derives SCK and WS from the single system clock instead of dividing an externally supplied SCK. It also supports TDM frames with more than two slots, a selectable WS format, and a configurable slot width. Per-edge strobes, slot/bit indices and a frame-start pulse let downstream deserialisers sample in the system clock domain without using SCK as a clock.

## Interface
- SCK_DIV, 2: system-clock cycles per SCK half-period (≥1).
- SLOT_BITS, 32: SCK periods per slot (≥2).
- NUM_SLOTS, 2: slots per frame (≥1; must be even when WS_MODE=0).
- WS_MODE, 0: 0 = I2S level WS (low for first half of slots, high for second half); 1 = TDM frame-sync pulse, one SCK period wide.
- WS_EARLY, 1: 1 = WS leads the slot boundary by one SCK period (Philips I2S); 0 = WS changes on the boundary (left-justified).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low = synchronous stop/clear.
- sck  out  1  bit clock to microphones.
- ws  out  1  word select / frame sync.
- sck_rise  out  1  one-clk strobe, high in the first cycle sck reads 1.
- sck_fall  out  1  one-clk strobe, high in the first cycle sck reads 0 after a high phase.
- bit_idx  out  clog2(SLOT_BITS)  bit position within slot (0 = MSB).
- slot_idx  out  max(1,clog2(NUM_SLOTS))  current slot.
- frame_start  out  1  one-clk pulse coincident with sck_fall when the position becomes (slot 0, bit 0).

## Operation
- Reset values (rst=1 or en=0): sck=0, ws=0, sck_rise=0, sck_fall=0, frame_start=0, div_cnt=0, bit_idx=SLOT_BITS-1, slot_idx=NUM_SLOTS-1. This is the "last bit of last slot" position, so the first falling edge starts frame 0.
- Divider: div_cnt counts 0..SCK_DIV-1 while en=1. At SCK_DIV-1 it wraps to 0, and sck toggles in the next cycle.
- Fall event: when sck toggles 1→0, the position advances:
  - bit_idx+1, wrapping at SLOT_BITS-1 to 0.
  - On the bit wrap, slot_idx+1, wrapping at NUM_SLOTS-1 to 0.
- Position outputs, ws, sck_fall and frame_start all update in the same cycle as sck.
- Rise events do not change the position.
- WS rule, with P = the new position, or the position one bit after it when WS_EARLY=1:
  - Mode 0: ws = (P.slot ≥ NUM_SLOTS/2).
  - Mode 1: ws = (P.slot==0 && P.bit==0).
- ws is held at 0 from reset until the first fall event.
- rst has priority over en. rst or en low mid-period aborts immediately: all outputs take their reset values the next cycle, and no partial strobe is emitted.
- en rising restarts from the reset state. Behaviour is identical to rst release.

## Timing
- Cycle 1 = first clk edge with rst=0, en=1.
- sck period = 2·SCK_DIV clk. Duty is 50% exactly.
- First rising edge of sck: sck=1 from cycle SCK_DIV+1. First falling edge: sck=0 from cycle 2·SCK_DIV+1.
- Frame period = 2·SCK_DIV·SLOT_BITS·NUM_SLOTS clk.
- Strobes are registered and are never high for two consecutive cycles when SCK_DIV≥2. With SCK_DIV=1, sck_rise and sck_fall alternate every cycle.
- No combinational path from inputs to outputs.

## Test plan
- Defaults (SCK_DIV=2, SLOT_BITS=32, NUM_SLOTS=2, WS_MODE=0, WS_EARLY=1), rst released, en=1:
  - sck=1 at cycles 3–4 and 0 at cycles 5–6.
  - sck_fall and frame_start high at cycle 5, with bit_idx=0, slot_idx=0.
  - ws rises at the fall where bit_idx=31, slot_idx=0 (cycle 129). ws falls at cycle 257 (bit 31, slot 1).
  - WS period 256 clk.
- Same config with WS_EARLY=0: ws rises at cycle 133 (slot_idx→1, bit 0) and stays high 128 clk. frame_start repeats every 256 clk.
- TDM (NUM_SLOTS=8, SLOT_BITS=16, WS_MODE=1, WS_EARLY=0, SCK_DIV=1):
  - ws high for exactly 2 clk starting at each frame_start.
  - frame_start every 256 clk.
  - slot_idx steps 0..7 and wraps.
- SCK_DIV=1: sck toggles every cycle. sck_rise and sck_fall alternate. The bit_idx wrap 15→0 is correct.
- en dropped at cycle 100 with defaults:
  - Cycle 101 shows sck=0, ws=0, bit_idx=31, slot_idx=1, all strobes 0.
  - After en is re-raised, the cycle-1 sequence repeats exactly.
- rst=1 with en=1 mid-frame: the same clear as the en-drop case. rst held with en toggling keeps all outputs at their reset values.

Source files
------------

// File: rtl/i2s_clock_gen.sv
// i2s_clock_gen: I2S/TDM bit-clock (SCK) and frame-clock (WS) generator derived from clk_i.
//
// Parameters:
//   SCK_DIV   clk_i cycles per SCK half-period (>= 1)
//   SLOT_BITS SCK periods per slot (>= 2)
//   NUM_SLOTS slots per frame (>= 1, even when WS_MODE = 0)
//   WS_MODE   0 = I2S level WS, 1 = TDM frame-sync pulse one SCK period wide
//   WS_EARLY  1 = WS leads the slot boundary by one SCK period, 0 = on the boundary
//
// Ports:
//   clk_i          system clock, all logic on the rising edge
//   rst_i          synchronous active-high reset (priority over en_i)
//   en_i           run enable; low clears to the reset state synchronously
//   sck_o          bit clock
//   ws_o           word select / frame sync
//   sck_rise_o     strobe in the first cycle sck_o reads 1
//   sck_fall_o     strobe in the first cycle sck_o reads 0 after a high phase
//   bit_idx_o      bit position within the slot (0 = MSB)
//   slot_idx_o     current slot
//   frame_start_o  strobe with sck_fall_o when the position becomes (slot 0, bit 0)
//
// All outputs come straight from registers; there is no combinational input-to-output path.
module i2s_clock_gen #(
  parameter int unsigned SCK_DIV   = 2,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned WS_MODE   = 0,
  parameter int unsigned WS_EARLY  = 1,
  localparam int unsigned BitW     = $clog2(SLOT_BITS),
  localparam int unsigned SlotW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             sck_o,
  output logic             ws_o,
  output logic             sck_rise_o,
  output logic             sck_fall_o,
  output logic [BitW-1:0]  bit_idx_o,
  output logic [SlotW-1:0] slot_idx_o,
  output logic             frame_start_o
);

  localparam int unsigned     DivW     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DivW-1:0]  DivLast  = DivW'(SCK_DIV - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(SLOT_BITS - 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(NUM_SLOTS - 1);
  localparam logic [SlotW-1:0] SlotHalf = SlotW'(NUM_SLOTS / 2);

  logic [DivW-1:0]  div_q, div_d;
  logic             tick_q, tick_d;
  logic             sck_q, sck_d;
  logic             ws_q, ws_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             fs_q, fs_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [SlotW-1:0] slot_q, slot_d;

  logic [BitW-1:0]  nxt_bit, p_bit;
  logic [SlotW-1:0] nxt_slot, p_slot;
  logic             ws_new;

  function automatic logic [BitW-1:0] bit_inc(input logic [BitW-1:0] b);
    return (b == BitLast) ? '0 : b + BitW'(1);
  endfunction

  function automatic logic [SlotW-1:0] slot_inc(input logic [BitW-1:0]  b,
                                                 input logic [SlotW-1:0] s);
    if (b != BitLast) return s;
    return (s == SlotLast) ? '0 : s + SlotW'(1);
  endfunction

  // Position after the coming fall event, and the WS reference position P.
  always_comb begin
    nxt_bit  = bit_inc(bit_q);
    nxt_slot = slot_inc(bit_q, slot_q);
    if (WS_EARLY != 0) begin
      p_bit  = bit_inc(nxt_bit);
      p_slot = slot_inc(nxt_bit, nxt_slot);
    end else begin
      p_bit  = nxt_bit;
      p_slot = nxt_slot;
    end
    if (WS_MODE == 0) begin
      ws_new = (p_slot >= SlotHalf);
    end else begin
      ws_new = (p_bit == '0) && (p_slot == '0);
    end
  end

  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    sck_d  = sck_q;
    ws_d   = ws_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    fs_d   = 1'b0;
    bit_d  = bit_q;
    slot_d = slot_q;
    if (!en_i) begin
      div_d  = '0;
      sck_d  = 1'b0;
      ws_d   = 1'b0;
      bit_d  = BitLast;
      slot_d = SlotLast;
    end else begin
      // tick_q marks the cycle after the divider wrap, so SCK changes one cycle later.
      if (div_q == DivLast) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + DivW'(1);
      end
      if (tick_q) begin
        sck_d = ~sck_q;
        if (sck_q) begin
          fall_d = 1'b1;
          bit_d  = nxt_bit;
          slot_d = nxt_slot;
          ws_d   = ws_new;
          fs_d   = (nxt_bit == '0) && (nxt_slot == '0);
        end else begin
          rise_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      sck_q  <= 1'b0;
      ws_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      fs_q   <= 1'b0;
      bit_q  <= BitLast;
      slot_q <= SlotLast;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      sck_q  <= sck_d;
      ws_q   <= ws_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      fs_q   <= fs_d;
      bit_q  <= bit_d;
      slot_q <= slot_d;
    end
  end

  assign sck_o         = sck_q;
  assign ws_o          = ws_q;
  assign sck_rise_o    = rise_q;
  assign sck_fall_o    = fall_q;
  assign bit_idx_o     = bit_q;
  assign slot_idx_o    = slot_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_i2s_clock_gen.sv
// Testbench for i2s_clock_gen: three configurations driven in lockstep (I2S early WS,
// I2S boundary WS, TDM SCK_DIV=1), checked every cycle against closed-form timing expectations
// queued at drive time, plus spot checks on WS / frame_start event cycles.
module tb_i2s_clock_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  // A: defaults. B: WS_EARLY=0. C: TDM.
  logic       a_sck, a_ws, a_rise, a_fall, a_fs;
  logic [4:0] a_bit;
  logic [0:0] a_slot;
  logic       b_sck, b_ws, b_rise, b_fall, b_fs;
  logic [4:0] b_bit;
  logic [0:0] b_slot;
  logic       c_sck, c_ws, c_rise, c_fall, c_fs;
  logic [3:0] c_bit;
  logic [2:0] c_slot;

  i2s_clock_gen u_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sck_o(a_sck), .ws_o(a_ws), .sck_rise_o(a_rise),
    .sck_fall_o(a_fall), .bit_idx_o(a_bit), .slot_idx_o(a_slot), .frame_start_o(a_fs)
  );

  i2s_clock_gen #(.WS_EARLY(0)) u_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sck_o(b_sck), .ws_o(b_ws), .sck_rise_o(b_rise),
    .sck_fall_o(b_fall), .bit_idx_o(b_bit), .slot_idx_o(b_slot), .frame_start_o(b_fs)
  );

  i2s_clock_gen #(
    .SCK_DIV(1), .SLOT_BITS(16), .NUM_SLOTS(8), .WS_MODE(1), .WS_EARLY(0)
  ) u_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sck_o(c_sck), .ws_o(c_ws), .sck_rise_o(c_rise),
    .sck_fall_o(c_fall), .bit_idx_o(c_bit), .slot_idx_o(c_slot), .frame_start_o(c_fs)
  );

  typedef struct {
    int          n;
    logic [20:0] a;
    logic [20:0] b;
    logic [20:0] c;
  } sb_t;

  sb_t q[$];
  int  n = 0;
  int  tests = 0;
  int  fails = 0;

  // Event capture (run phase only).
  logic track = 1'b0;
  logic a_ws_p = 1'b0, b_ws_p = 1'b0;
  int   a_rise1 = -1, a_rise2 = -1, a_fall1 = -1;
  int   b_rise1 = -1, b_fall1 = -1, b_fs1 = -1, b_fs2 = -1;
  int   c_fs1 = -1, c_fs2 = -1;

  function automatic logic [20:0] pk(input logic sck, input logic ws, input logic r,
                                     input logic f, input logic fs, input logic [7:0] s,
                                     input logic [7:0] b);
    return {sck, ws, r, f, fs, s, b};
  endfunction

  // Expected outputs at run cycle n (0 = reset state), derived from the timing rules.
  function automatic logic [20:0] model(input int n_i, input int d, input int sb, input int ns,
                                        input int mode, input int early);
    int   h, f, k, l, b, s, pb, ps;
    logic sck, r, fl, ws, fs;
    if (n_i == 0) return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(ns - 1), 8'(sb - 1));
    h   = (n_i - 1) / d;
    sck = (h % 2) == 1;
    r   = ((n_i - 1) % d == 0) && (h % 2 == 1);
    fl  = ((n_i - 1) % d == 0) && (h % 2 == 0) && (h >= 2);
    f   = h / 2;
    if (f == 0) begin
      b  = sb - 1;
      s  = ns - 1;
      ws = 1'b0;
    end else begin
      k  = f - 1;
      b  = k % sb;
      s  = (k / sb) % ns;
      l  = k + early;
      pb = l % sb;
      ps = (l / sb) % ns;
      ws = (mode == 0) ? (ps >= ns / 2) : ((pb == 0) && (ps == 0));
    end
    fs = fl && (b == 0) && (s == 0);
    return pk(sck, ws, r, fl, fs, 8'(s), 8'(b));
  endfunction

  task automatic check(input string tag, input int cyc, input logic [20:0] obs,
                       input logic [20:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    sb_t e;
    if (rst || !en) n = 0;
    else n = n + 1;
    e.n = n;
    e.a = model(n, 2, 32, 2, 0, 1);
    e.b = model(n, 2, 32, 2, 0, 0);
    e.c = model(n, 1, 16, 8, 1, 0);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("cfgA", e.n, pk(a_sck, a_ws, a_rise, a_fall, a_fs, 8'(a_slot), 8'(a_bit)), e.a);
    check("cfgB", e.n, pk(b_sck, b_ws, b_rise, b_fall, b_fs, 8'(b_slot), 8'(b_bit)), e.b);
    check("cfgC", e.n, pk(c_sck, c_ws, c_rise, c_fall, c_fs, 8'(c_slot), 8'(c_bit)), e.c);
    if (track) begin
      if (a_ws && !a_ws_p) begin
        if (a_rise1 < 0) a_rise1 = e.n;
        else if (a_rise2 < 0) a_rise2 = e.n;
      end
      if (!a_ws && a_ws_p && a_fall1 < 0) a_fall1 = e.n;
      if (b_ws && !b_ws_p && b_rise1 < 0) b_rise1 = e.n;
      if (!b_ws && b_ws_p && b_fall1 < 0) b_fall1 = e.n;
      if (b_fs) begin
        if (b_fs1 < 0) b_fs1 = e.n;
        else if (b_fs2 < 0) b_fs2 = e.n;
      end
      if (c_fs) begin
        if (c_fs1 < 0) c_fs1 = e.n;
        else if (c_fs2 < 0) c_fs2 = e.n;
      end
    end
    a_ws_p = a_ws;
    b_ws_p = b_ws;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) step();

    // Free run from reset release.
    rst   = 1'b0;
    track = 1'b1;
    repeat (600) step();
    track = 1'b0;
    check_int("a_ws_first_rise", a_rise1, 129);
    check_int("a_ws_first_fall", a_fall1, 257);
    check_int("a_ws_period", a_rise2 - a_rise1, 256);
    check_int("b_ws_first_rise", b_rise1, 133);
    check_int("b_ws_high_len", b_fall1 - b_rise1, 128);
    check_int("b_frame_period", b_fs2 - b_fs1, 256);
    check_int("c_first_frame", c_fs1, 3);
    check_int("c_frame_period", c_fs2 - c_fs1, 256);

    // en dropped after cycle 100, then re-raised: restart from cycle 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (100) step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (40) step();

    // rst asserted mid-frame with en high, then held while en toggles.
    repeat (300) step();
    rst = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 6; i++) begin
      en = ~en;
      step();
    end
    en  = 1'b1;
    rst = 1'b0;
    repeat (60) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
